// File: rtl/jtag_dmi_pkg.sv
// Shared types for the JTAG ACCESS responder: TAP states, IR codes, DMI op/status and DR layout.
// Pure declarations, no logic; consumed by the TAP FSM, the top level and the bench.
package jtag_dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_ACCESS  = 5'h11;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_RSVD = 2'd1,
    ST_ERR  = 2'd2,
    ST_BUSY = 2'd3
  } dmi_status_e;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
    logic [1:0]            op;
  } access_dr_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// Pin synchronisers, TCK edge detect and the 16-state TAP controller.
// Edges surface 2 cycles after the pin, state moves on the 3rd; no backpressure.
module jtag_tap_fsm
  import jtag_dmi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tck_i,
  input  logic       tms_i,
  input  logic       tdi_i,
  input  logic       trst_ni,
  output tap_state_e state,
  output logic       tck_rise,
  output logic       tck_fall,
  output logic       tdi_s
);

  logic [1:0] tck_q, tms_q, tdi_q, trst_q;
  logic       tck_d;
  tap_state_e state_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_q  <= 2'b00;
      tms_q  <= 2'b00;
      tdi_q  <= 2'b00;
      trst_q <= 2'b11;
      tck_d  <= 1'b0;
    end else begin
      tck_q  <= {tck_q[0], tck_i};
      tms_q  <= {tms_q[0], tms_i};
      tdi_q  <= {tdi_q[0], tdi_i};
      trst_q <= {trst_q[0], trst_ni};
      tck_d  <= tck_q[1];
    end
  end

  assign tck_rise = tck_q[1] & ~tck_d;
  assign tck_fall = ~tck_q[1] & tck_d;
  assign tdi_s    = tdi_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i || !trst_q[1]) state <= TLR;
    else                     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tck_rise) begin
      case (state)
        TLR:     state_nxt = tms_q[1] ? TLR    : RTI;
        RTI:     state_nxt = tms_q[1] ? SEL_DR : RTI;
        SEL_DR:  state_nxt = tms_q[1] ? SEL_IR : CAP_DR;
        CAP_DR:  state_nxt = tms_q[1] ? EX1_DR : SH_DR;
        SH_DR:   state_nxt = tms_q[1] ? EX1_DR : SH_DR;
        EX1_DR:  state_nxt = tms_q[1] ? UPD_DR : PAU_DR;
        PAU_DR:  state_nxt = tms_q[1] ? EX2_DR : PAU_DR;
        EX2_DR:  state_nxt = tms_q[1] ? UPD_DR : SH_DR;
        UPD_DR:  state_nxt = tms_q[1] ? SEL_DR : RTI;
        SEL_IR:  state_nxt = tms_q[1] ? TLR    : CAP_IR;
        CAP_IR:  state_nxt = tms_q[1] ? EX1_IR : SH_IR;
        SH_IR:   state_nxt = tms_q[1] ? EX1_IR : SH_IR;
        EX1_IR:  state_nxt = tms_q[1] ? UPD_IR : PAU_IR;
        PAU_IR:  state_nxt = tms_q[1] ? EX2_IR : PAU_IR;
        EX2_IR:  state_nxt = tms_q[1] ? UPD_IR : SH_IR;
        UPD_IR:  state_nxt = tms_q[1] ? SEL_DR : RTI;
        default: state_nxt = TLR;
      endcase
    end
  end

endmodule

// File: rtl/jtag_dmi_responder.sv
// JTAG TAP with IDCODE/BYPASS/ACCESS; ACCESS updates become valid/ready bus requests.
// Request issues 1 cycle after Update-DR and holds until ready; new ops while busy are dropped as BUSY.
module jtag_dmi_responder
  import jtag_dmi_pkg::*;
#(
  parameter int          ADDR_W = 7,
  parameter int          DATA_W = 32,
  parameter logic [31:0] IDCODE = 32'h1000_1DB3,
  parameter int          IR_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tck_i,
  input  logic              tms_i,
  input  logic              tdi_i,
  input  logic              trst_ni,
  output logic              tdo_o,
  output logic              tdo_oe_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              rsp_valid_i,
  input  logic              rsp_err_i,
  input  logic [DATA_W-1:0] rsp_rdata_i
);

  localparam int DR_W = 2 + ADDR_W + DATA_W;

  tap_state_e        state;
  logic              tck_rise, tck_fall, tdi_s;
  logic [IR_W-1:0]   ir, ir_sh;
  logic [DR_W-1:0]   dr_sh, cap_val, shf_val;
  dmi_status_e       status, status_eff;
  logic              outstanding, pend_read;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_rdata;
  logic              ir_access, ir_idcode;
  dmi_op_e           dr_op;
  logic              upd_dr, rsp_hit, busy_eff, is_rw;

  jtag_tap_fsm u_tap (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tck_i    (tck_i),
    .tms_i    (tms_i),
    .tdi_i    (tdi_i),
    .trst_ni  (trst_ni),
    .state    (state),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tdi_s    (tdi_s)
  );

  assign ir_access = (ir == IR_W'(IR_ACCESS));
  assign ir_idcode = (ir == IR_W'(IR_IDCODE));
  assign tdo_oe_o  = (state == SH_DR) || (state == SH_IR);

  always_comb begin
    cap_val = '0;
    shf_val = DR_W'(tdi_s);
    if (ir_access) begin
      cap_val = {last_addr, last_rdata, status};
      shf_val = {tdi_s, dr_sh[DR_W-1:1]};
    end else if (ir_idcode) begin
      cap_val = DR_W'(IDCODE);
      shf_val = DR_W'({tdi_s, dr_sh[31:1]});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir    <= IR_W'(IR_IDCODE);
      ir_sh <= '0;
      dr_sh <= '0;
      tdo_o <= 1'b0;
    end else begin
      if (state == TLR) ir <= IR_W'(IR_IDCODE);
      if (tck_rise) begin
        case (state)
          CAP_IR:  ir_sh <= IR_W'(IR_CAPTURE);
          SH_IR:   ir_sh <= {tdi_s, ir_sh[IR_W-1:1]};
          CAP_DR:  dr_sh <= cap_val;
          SH_DR:   dr_sh <= shf_val;
          default: ;
        endcase
      end
      if (tck_fall) begin
        if (state == UPD_IR) ir <= ir_sh;
        case (state)
          SH_DR:   tdo_o <= dr_sh[0];
          SH_IR:   tdo_o <= ir_sh[0];
          default: tdo_o <= 1'b0;
        endcase
      end
    end
  end

  // A response landing in the same cycle as Update-DR retires the old request before the new op is judged.
  assign dr_op      = dmi_op_e'(dr_sh[1:0]);
  assign upd_dr     = tck_fall && (state == UPD_DR) && ir_access;
  assign rsp_hit    = rsp_valid_i && outstanding;
  assign busy_eff   = outstanding && !rsp_valid_i;
  assign status_eff = (rsp_hit && rsp_err_i) ? ST_ERR : status;
  assign is_rw      = (dr_op == OP_READ) || (dr_op == OP_WRITE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_o <= 1'b0;
      req_we_o    <= 1'b0;
      req_addr_o  <= '0;
      req_wdata_o <= '0;
      status      <= ST_OK;
      outstanding <= 1'b0;
      pend_read   <= 1'b0;
      last_addr   <= '0;
      last_rdata  <= '0;
    end else begin
      if (req_valid_o && req_ready_i) req_valid_o <= 1'b0;
      if (rsp_hit) begin
        outstanding <= 1'b0;
        if (pend_read) last_rdata <= rsp_rdata_i;
      end
      status <= status_eff;
      if (upd_dr) begin
        if (!is_rw) begin
          status <= ST_OK;
        end else if (busy_eff) begin
          status <= ST_BUSY;
        end else if (status_eff == ST_OK) begin
          req_valid_o <= 1'b1;
          req_we_o    <= (dr_op == OP_WRITE);
          req_addr_o  <= dr_sh[DR_W-1:DATA_W+2];
          req_wdata_o <= dr_sh[DATA_W+1:2];
          last_addr   <= dr_sh[DR_W-1:DATA_W+2];
          outstanding <= 1'b1;
          pend_read   <= (dr_op == OP_READ);
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dmi_responder.sv
// Directed bench for jtag_dmi_responder: IDCODE, BYPASS, ACCESS read/write, busy, TRST and reset.
// TCK phases are 5 system clocks; outputs sampled on the falling system clock edge.
module tb_jtag_dmi_responder;
  import jtag_dmi_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, tck_i, tms_i, tdi_i, trst_ni;
  logic        tdo_o, tdo_oe_o;
  logic        req_valid_o, req_ready_i, req_we_o;
  logic [6:0]  req_addr_o;
  logic [31:0] req_wdata_o;
  logic        rsp_valid_i, rsp_err_i;
  logic [31:0] rsp_rdata_i;

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  jtag_dmi_responder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tck_i       (tck_i),
    .tms_i       (tms_i),
    .tdi_i       (tdi_i),
    .trst_ni     (trst_ni),
    .tdo_o       (tdo_o),
    .tdo_oe_o    (tdo_oe_o),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .req_we_o    (req_we_o),
    .req_addr_o  (req_addr_o),
    .req_wdata_o (req_wdata_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_err_i   (rsp_err_i),
    .rsp_rdata_i (rsp_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (req_valid_o && req_ready_i) beats <= beats + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] acc(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    access_dr_t v;
    v.addr = a;
    v.data = d;
    v.op   = op;
    return 64'(v);
  endfunction

  task automatic tick(input logic tms, input logic tdi, output logic tdo);
    tms_i = tms;
    tdi_i = tdi;
    repeat (5) @(negedge clk_i);
    tdo   = tdo_o;
    tck_i = 1'b1;
    repeat (5) @(negedge clk_i);
    tck_i = 1'b0;
  endtask

  task automatic shift_body(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic t;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], t);
      dout[i] = t;
    end
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic t;
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
    tick(1'b0, 1'b0, t);
    shift_body(n, din, dout);
  endtask

  task automatic scan_ir(input logic [4:0] code, output logic [63:0] dout);
    logic t;
    tick(1'b1, 1'b0, t);
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
    tick(1'b0, 1'b0, t);
    shift_body(5, 64'(code), dout);
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // Ready is withheld for 3 cycles, then a one-cycle handshake; valid must drop right after.
  task automatic accept(input string tag);
    repeat (3) @(negedge clk_i);
    check({tag, "_held"}, 64'(req_valid_o), 64'd1);
    req_ready_i = 1'b1;
    @(negedge clk_i);
    req_ready_i = 1'b0;
    check({tag, "_drop"}, 64'(req_valid_o), 64'd0);
  endtask

  task automatic respond(input logic err, input logic [31:0] rdata);
    rsp_valid_i = 1'b1;
    rsp_err_i   = err;
    rsp_rdata_i = rdata;
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
    rsp_err_i   = 1'b0;
    rsp_rdata_i = '0;
  endtask

  initial begin
    logic [63:0] dout;
    logic        t;
    rst_i = 1'b1; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; trst_ni = 1'b1;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_err_i = 1'b0; rsp_rdata_i = '0;
    repeat (4) @(negedge clk_i);
    check("rst_tdo", 64'(tdo_o), 64'd0);
    check("rst_oe", 64'(tdo_oe_o), 64'd0);
    check("rst_valid", 64'(req_valid_o), 64'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
    scan_dr(32, 64'd0, dout);
    check("idcode", dout, 64'h1000_1DB3);
    scan_ir(5'h01, dout);
    check("ir_capture", dout, 64'h01);

    scan_ir(5'h1F, dout);
    scan_dr(8, 64'hA5, dout);
    check("bypass", dout, 64'h4A);

    scan_ir(5'h11, dout);
    scan_dr(41, acc(7'h10, 32'hDEAD_BEEF, 2'd2), dout);
    check("wr_cap", dout, 64'd0);
    wait_valid("wr_valid");
    check("wr_we", 64'(req_we_o), 64'd1);
    check("wr_addr", 64'(req_addr_o), 64'h10);
    check("wr_data", 64'(req_wdata_o), 64'hDEAD_BEEF);
    accept("wr");
    check("wr_beats", 64'(beats), 64'd1);
    respond(1'b0, 32'h0);

    scan_dr(41, acc(7'h11, 32'h0, 2'd1), dout);
    check("rd_cap", dout, acc(7'h10, 32'h0, 2'd0));
    wait_valid("rd_valid");
    check("rd_we", 64'(req_we_o), 64'd0);
    check("rd_addr", 64'(req_addr_o), 64'h11);
    accept("rd");
    respond(1'b0, 32'h1234_5678);
    scan_dr(41, acc(7'h0, 32'h0, 2'd0), dout);
    check("rd_result", dout, acc(7'h11, 32'h1234_5678, 2'd0));

    scan_dr(41, acc(7'h20, 32'hCAFE_F00D, 2'd2), dout);
    check("b1_cap", dout, acc(7'h11, 32'h1234_5678, 2'd0));
    wait_valid("b1_valid");
    accept("b1");
    scan_dr(41, acc(7'h21, 32'h1, 2'd2), dout);
    check("b2_cap", dout, acc(7'h20, 32'h1234_5678, 2'd0));
    repeat (20) @(negedge clk_i);
    check("b2_no_req", 64'(req_valid_o), 64'd0);
    check("b2_beats", 64'(beats), 64'd3);
    scan_dr(41, acc(7'h0, 32'h0, 2'd0), dout);
    check("busy_status", dout, acc(7'h20, 32'h1234_5678, 2'd3));
    respond(1'b0, 32'h0);
    scan_dr(41, acc(7'h22, 32'h55AA_55AA, 2'd2), dout);
    check("cleared_cap", dout, acc(7'h20, 32'h1234_5678, 2'd0));
    wait_valid("b3_valid");
    check("b3_addr", 64'(req_addr_o), 64'h22);
    accept("b3");
    respond(1'b0, 32'h0);

    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
    tick(1'b0, 1'b0, t);
    tick(1'b0, 1'b1, t);
    check("shdr_oe", 64'(tdo_oe_o), 64'd1);
    trst_ni = 1'b0;
    repeat (5) @(negedge clk_i);
    check("trst_oe", 64'(tdo_oe_o), 64'd0);
    trst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    tick(1'b0, 1'b0, t);
    scan_dr(32, 64'd0, dout);
    check("trst_idcode", dout, 64'h1000_1DB3);

    scan_ir(5'h11, dout);
    scan_dr(41, acc(7'h30, 32'h0BAD_F00D, 2'd2), dout);
    check("r_cap", dout, acc(7'h22, 32'h1234_5678, 2'd0));
    wait_valid("r_valid");
    rst_i = 1'b1;
    @(negedge clk_i);
    check("r_drop", 64'(req_valid_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    respond(1'b1, 32'hFFFF_FFFF);
    tick(1'b0, 1'b0, t);
    scan_ir(5'h11, dout);
    scan_dr(41, acc(7'h0, 32'h0, 2'd0), dout);
    check("late_rsp_ignored", dout, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
